req_gnt_tracker: RTL and testbench
==================================

// Module: req_gnt_tracker
// PURPOSE
//  Synthesizable multi-channel request/grant pairing monitor.
//  Sits beside a req/gnt interface and matches every rising req to a later
//    rising gnt, in order.
//  Tracks many outstanding requests per channel. Reports each pair's latency,
//    plus orphan grants, request overflow and timeouts.
// PARAMETERS
//  NUM_CH   4   independent req/gnt channels
//  DEPTH    4   max outstanding requests per channel (power of 2, >=2)
//  TS_W     8   free-running timestamp width; latency arithmetic is mod 2**TS_W
//  MAX_LAT  32  cycles after which oldest unmatched request times out (1..2**TS_W-1)
// PORTS
//  clk          in   1            clock, all logic on posedge
//  rst_n        in   1            reset: synchronous, active-low
//  req          in   NUM_CH       request level per channel
//  gnt          in   NUM_CH       grant level per channel
//  done_vld     out  NUM_CH       1-cycle pulse: a request was matched
//  done_lat     out  NUM_CH*TS_W  matched latency in cycles, ch i at [i*TS_W +: TS_W]
//  err_orphan   out  NUM_CH       1-cycle pulse: grant edge with nothing outstanding
//  err_ovf      out  NUM_CH       1-cycle pulse: request edge dropped, channel full
//  err_tmo      out  NUM_CH       1-cycle pulse: oldest request reached MAX_LAT
//  outstanding  out  NUM_CH*($clog2(DEPTH)+1)  live count per channel
// BEHAVIOUR
//  Reset: all outputs 0; FIFOs empty; timestamp counter 0; req_q/gnt_q 0.
//    A req or gnt held high through reset therefore counts as a rise in the
//    first cycle after reset.
//  Edges: rise = level & ~level_q, sampled at posedge.
//  Timestamp: now increments every cycle and wraps.
//  Request rise: push now into the channel FIFO.
//    If the FIFO is full and no pop happens this cycle: drop the request,
//    err_ovf=1, count unchanged.
//  Grant rise, FIFO non-empty: pop the oldest entry.
//    done_vld=1, done_lat=(now-ts) mod 2**TS_W, always >=1.
//  Grant rise, FIFO empty: err_orphan=1.
//  Same-cycle req rise and gnt rise:
//    The grant never matches the same-cycle request (matching needs >=1 cycle).
//    Empty FIFO -> err_orphan and the request is pushed.
//    Full FIFO -> pop and push both happen; no overflow.
//  Timeout: oldest entry with (now-ts)==MAX_LAT and no grant rise this cycle
//    -> err_tmo=1 and the entry is popped. At most one timeout per channel
//    per cycle.
//  A grant rise in the timeout cycle matches normally: done_lat=MAX_LAT, no err_tmo.
//  Output timing: all pulses/values registered, asserted the cycle after the
//    sampling edge.
//  Channels are fully independent; there is no cross-channel ordering.
//  Reset mid-operation: FIFOs flushed; no pulses for discarded entries.
// CONFIGURATION
//  REQ_GNT_TRK_STATS_EN defined: add output port
//    max_lat  out  NUM_CH*TS_W  per-channel max done_lat since reset.
//    Updated the same cycle done_vld rises. Reset value 0. Saturates, no wrap.
//  Not defined: port and logic absent; all other behaviour identical.
// STRUCTURE
//  req_gnt_pkg holds:
//    function lat_calc(now, ts)  modular subtract
//    typedef trk_err_e {ERR_NONE, ERR_ORPHAN, ERR_OVF, ERR_TMO}  internal encode
//  Sub-module req_gnt_ts_fifo:
//    DEPTH x TS_W sync FIFO with push, pop, head, count.
//    Simultaneous push+pop legal when full.
//    Instantiated NUM_CH times via generate.
// TESTING
//  1 req rise @c2, gnt rise @c7 (ch0)
//      -> done_vld @c8, done_lat=5, outstanding 1->0.
//  2 req @c2 & c5, gnt @c9 & c14
//      -> done_lat 7 then 9. In-order pairing; the second grant is not
//         credited to the first request.
//  3 gnt rise with no req
//      -> err_orphan single pulse, done_vld stays 0.
//  4 DEPTH+1 req rises, no gnt
//      -> last one raises err_ovf, outstanding=DEPTH.
//  5 single req, no gnt
//      -> err_tmo exactly MAX_LAT+1 cycles after the rise; outstanding back to 0.
//  6 rst_n=0 with 3 outstanding, released, then one gnt rise
//      -> err_orphan and no done_vld.
//      With REQ_GNT_TRK_STATS_EN: max_lat=0.

Source files
------------

// File: rtl/req_gnt_pkg.sv
// Shared types and helpers for the request/grant pairing monitor.
package req_gnt_pkg;

   typedef enum logic [1:0] {
      ERR_NONE,
      ERR_ORPHAN,
      ERR_OVF,
      ERR_TMO
   } trk_err_e;

   localparam int LAT_W_MAX = 32;

   // Timestamps wrap, so latency is a plain modular difference; callers truncate to TS_W.
   function automatic logic [LAT_W_MAX-1:0] lat_calc(input logic [LAT_W_MAX-1:0] now,
                                                     input logic [LAT_W_MAX-1:0] ts);
      return now - ts;
   endfunction

endpackage

// File: rtl/req_gnt_ts_fifo.sv
// DEPTH x TS_W synchronous timestamp FIFO; push and pop may coincide, including when full.
module req_gnt_ts_fifo
   import req_gnt_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int TS_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [TS_W-1:0]          din,
   output logic [TS_W-1:0]          head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [TS_W-1:0] mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic            full;
   logic            do_push;
   logic            do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data only; pointers define what is live.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/req_gnt_tracker.sv
// Multi-channel req/gnt pairing monitor: in-order matching, latency, orphan/overflow/timeout pulses.
// Optional REQ_GNT_TRK_STATS_EN adds per-channel max_lat output.
module req_gnt_tracker
   import req_gnt_pkg::*;
#(
   parameter int NUM_CH  = 4,
   parameter int DEPTH   = 4,
   parameter int TS_W    = 8,
   parameter int MAX_LAT = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [NUM_CH-1:0]                    req,
   input  logic [NUM_CH-1:0]                    gnt,
   output logic [NUM_CH-1:0]                    done_vld,
   output logic [NUM_CH*TS_W-1:0]               done_lat,
   output logic [NUM_CH-1:0]                    err_orphan,
   output logic [NUM_CH-1:0]                    err_ovf,
   output logic [NUM_CH-1:0]                    err_tmo,
   output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]  outstanding
`ifdef REQ_GNT_TRK_STATS_EN
   ,
   output logic [NUM_CH*TS_W-1:0]               max_lat
`endif
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [TS_W-1:0]                  now;
   logic [NUM_CH-1:0]                req_q, gnt_q, req_rise, gnt_rise;
   logic [NUM_CH-1:0]                push, pop, match_p0, tmo_p0;
   logic [NUM_CH-1:0][TS_W-1:0]      head_ts, head_lat;
   logic [NUM_CH-1:0][CNT_W-1:0]     cnt;
   trk_err_e [NUM_CH-1:0]            err_p0;

`ifdef REQ_GNT_TRK_STATS_EN
   function automatic logic [TS_W-1:0] sat_max(input logic [TS_W-1:0] cur,
                                                input logic [TS_W-1:0] lat);
      return (lat > cur) ? lat : cur;
   endfunction
`endif

   assign req_rise = req & ~req_q;
   assign gnt_rise = gnt & ~gnt_q;

   for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
      req_gnt_ts_fifo #(
         .DEPTH (DEPTH),
         .TS_W  (TS_W)
      ) u_fifo (
         .clk   (clk),
         .rst_n (rst_n),
         .push  (push[ch]),
         .pop   (pop[ch]),
         .din   (now),
         .head  (head_ts[ch]),
         .count (cnt[ch])
      );
      assign head_lat[ch] = TS_W'(lat_calc(LAT_W_MAX'(now), LAT_W_MAX'(head_ts[ch])));
      assign outstanding[ch*CNT_W +: CNT_W] = cnt[ch];
   end

   // Stage p0: decide match / timeout / push per channel from sampled edges.
   always_comb begin
      match_p0 = '0;
      tmo_p0   = '0;
      pop      = '0;
      push     = '0;
      err_p0   = {NUM_CH{ERR_NONE}};
      for (int c = 0; c < NUM_CH; c++) begin
         match_p0[c] = gnt_rise[c] && (cnt[c] != '0);
         tmo_p0[c]   = !gnt_rise[c] && (cnt[c] != '0) && (head_lat[c] == TS_W'(MAX_LAT));
         pop[c]      = match_p0[c] || tmo_p0[c];
         push[c]     = req_rise[c] && ((cnt[c] != CNT_W'(DEPTH)) || pop[c]);
         if (gnt_rise[c] && (cnt[c] == '0))
            err_p0[c] = ERR_ORPHAN;
         else if (req_rise[c] && !push[c])
            err_p0[c] = ERR_OVF;
         else if (tmo_p0[c])
            err_p0[c] = ERR_TMO;
      end
   end

   // Stage p1: registered pulses and values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         now        <= '0;
         req_q      <= '0;
         gnt_q      <= '0;
         done_vld   <= '0;
         done_lat   <= '0;
         err_orphan <= '0;
         err_ovf    <= '0;
         err_tmo    <= '0;
`ifdef REQ_GNT_TRK_STATS_EN
         max_lat    <= '0;
`endif
      end else begin
         now   <= now + 1'b1;
         req_q <= req;
         gnt_q <= gnt;
         for (int c = 0; c < NUM_CH; c++) begin
            done_vld[c]                 <= match_p0[c];
            done_lat[c*TS_W +: TS_W]    <= match_p0[c] ? head_lat[c] : '0;
            err_orphan[c]               <= (err_p0[c] == ERR_ORPHAN);
            err_ovf[c]                  <= (err_p0[c] == ERR_OVF);
            err_tmo[c]                  <= (err_p0[c] == ERR_TMO);
`ifdef REQ_GNT_TRK_STATS_EN
            if (match_p0[c])
               max_lat[c*TS_W +: TS_W] <= sat_max(max_lat[c*TS_W +: TS_W], head_lat[c]);
`endif
         end
      end
   end

endmodule

// File: tb/tb_req_gnt_tracker.sv
// Self-checking bench for req_gnt_tracker: queue-based reference model plus directed literal checks.
module tb_req_gnt_tracker;

   localparam int NUM_CH  = 4;
   localparam int DEPTH   = 4;
   localparam int TS_W    = 8;
   localparam int MAX_LAT = 32;
   localparam int CNT_W   = 3;
   localparam int TS_MOD  = 256;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic [NUM_CH-1:0]          req, gnt;
   logic [NUM_CH-1:0]          done_vld, err_orphan, err_ovf, err_tmo;
   logic [NUM_CH*TS_W-1:0]     done_lat;
   logic [NUM_CH*CNT_W-1:0]    outstanding;
`ifdef REQ_GNT_TRK_STATS_EN
   logic [NUM_CH*TS_W-1:0]     max_lat;
`endif

   int checks = 0;
   int errors = 0;

   req_gnt_tracker #(
      .NUM_CH  (NUM_CH),
      .DEPTH   (DEPTH),
      .TS_W    (TS_W),
      .MAX_LAT (MAX_LAT)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .gnt         (gnt),
      .done_vld    (done_vld),
      .done_lat    (done_lat),
      .err_orphan  (err_orphan),
      .err_ovf     (err_ovf),
      .err_tmo     (err_tmo),
      .outstanding (outstanding)
`ifdef REQ_GNT_TRK_STATS_EN
      ,
      .max_lat     (max_lat)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s ch%0d actual=%0d required=%0d @%0t", name, ch, act, exp, $time);
      end
   endtask

   // Reference model: one queue of request timestamps per channel.
   int          q [NUM_CH][$];
   int          m_now;
   bit          mdl_on = 1'b0;
   bit [NUM_CH-1:0] p_req, p_gnt;
   bit [NUM_CH-1:0] e_done, e_orph, e_ovf, e_tmo;
   int          e_lat [NUM_CH];
   int          e_cnt [NUM_CH];
   int          e_max [NUM_CH];

   task automatic model_step();
      int age;
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            q[c].delete();
            e_lat[c] = 0; e_cnt[c] = 0; e_max[c] = 0;
         end
         m_now = 0; p_req = '0; p_gnt = '0;
         e_done = '0; e_orph = '0; e_ovf = '0; e_tmo = '0;
         mdl_on = 1'b1;
      end else if (mdl_on) begin
         for (int c = 0; c < NUM_CH; c++) begin
            e_done[c] = 0; e_orph[c] = 0; e_ovf[c] = 0; e_tmo[c] = 0;
            age = (q[c].size() > 0) ? (m_now - q[c][0] + TS_MOD) % TS_MOD : -1;
            if (gnt[c] && !p_gnt[c]) begin
               if (q[c].size() > 0) begin
                  e_done[c] = 1;
                  e_lat[c]  = age;
                  if (age > e_max[c]) e_max[c] = age;
                  void'(q[c].pop_front());
               end else begin
                  e_orph[c] = 1;
               end
            end else if (age == MAX_LAT) begin
               e_tmo[c] = 1;
               void'(q[c].pop_front());
            end
            if (req[c] && !p_req[c]) begin
               if (q[c].size() < DEPTH) q[c].push_back(m_now);
               else e_ovf[c] = 1;
            end
            e_cnt[c] = q[c].size();
         end
         p_req = req; p_gnt = gnt;
         m_now = (m_now + 1) % TS_MOD;
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         if (mdl_on) begin
            for (int c = 0; c < NUM_CH; c++) begin
               chk("done_vld", c, 32'(done_vld[c]), 32'(e_done[c]));
               if (e_done[c]) chk("done_lat", c, 32'(done_lat[c*TS_W +: TS_W]), e_lat[c]);
               chk("err_orphan", c, 32'(err_orphan[c]), 32'(e_orph[c]));
               chk("err_ovf", c, 32'(err_ovf[c]), 32'(e_ovf[c]));
               chk("err_tmo", c, 32'(err_tmo[c]), 32'(e_tmo[c]));
               chk("outstanding", c, 32'(outstanding[c*CNT_W +: CNT_W]), e_cnt[c]);
`ifdef REQ_GNT_TRK_STATS_EN
               chk("max_lat", c, 32'(max_lat[c*TS_W +: TS_W]), e_max[c]);
`endif
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog ch0 actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_n = 1'b0; req = '0; gnt = '0;
      repeat (3) @(negedge clk);
      chk("rst_done_vld", 0, 32'(done_vld), 0);
      chk("rst_errs", 0, 32'({err_orphan, err_ovf, err_tmo}), 0);
      chk("rst_outstanding", 0, 32'(outstanding), 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single pair, latency 5.
      req[0] = 1'b1;
      repeat (5) @(negedge clk);
      chk("t1_outstanding_before", 0, 32'(outstanding[0 +: CNT_W]), 1);
      chk("t1_no_done_yet", 0, 32'(done_vld[0]), 0);
      gnt[0] = 1'b1;
      @(negedge clk);
      chk("t1_done_vld", 0, 32'(done_vld[0]), 1);
      chk("t1_done_lat", 0, 32'(done_lat[0 +: TS_W]), 5);
      chk("t1_outstanding_after", 0, 32'(outstanding[0 +: CNT_W]), 0);
      req[0] = 1'b0; gnt[0] = 1'b0;
      @(negedge clk);

      // Orphan grant on ch1.
      gnt[1] = 1'b1;
      @(negedge clk);
      chk("t3_orphan", 1, 32'(err_orphan[1]), 1);
      chk("t3_no_done", 1, 32'(done_vld[1]), 0);
      @(negedge clk);
      chk("t3_orphan_single", 1, 32'(err_orphan[1]), 0);
      gnt[1] = 1'b0;

      // DEPTH+1 requests on ch2.
      for (int i = 0; i <= DEPTH; i++) begin
         req[2] = 1'b1;
         @(negedge clk);
         chk("t4_ovf", 2, 32'(err_ovf[2]), (i == DEPTH) ? 1 : 0);
         req[2] = 1'b0;
         @(negedge clk);
      end
      chk("t4_outstanding_full", 2, 32'(outstanding[2*CNT_W +: CNT_W]), DEPTH);

      // Timeout on ch3.
      req[3] = 1'b1;
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (err_tmo[3]) break;
      end
      chk("t5_tmo_delay", 3, n, MAX_LAT + 1);
      chk("t5_outstanding", 3, 32'(outstanding[3*CNT_W +: CNT_W]), 0);
      req[3] = 1'b0;
      @(negedge clk);

      // Reset flushes outstanding entries.
      for (int i = 0; i < 3; i++) begin
         req[0] = 1'b1; @(negedge clk);
         req[0] = 1'b0; @(negedge clk);
      end
      chk("t6_outstanding_pre", 0, 32'(outstanding[0 +: CNT_W]), 3);
      rst_n = 1'b0;
      @(negedge clk);
      chk("t6_flushed", 0, 32'(outstanding), 0);
      rst_n = 1'b1;
      gnt[0] = 1'b1;
      @(negedge clk);
      chk("t6_orphan", 0, 32'(err_orphan[0]), 1);
      chk("t6_no_done", 0, 32'(done_vld[0]), 0);
`ifdef REQ_GNT_TRK_STATS_EN
      chk("t6_max_lat", 0, 32'(max_lat[0 +: TS_W]), 0);
`endif
      gnt[0] = 1'b0;
      @(negedge clk);

      // Randomized traffic with rare resets.
      for (int k = 0; k < 3000; k++) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if ($urandom_range(0, 99) < 30) req[c] = ~req[c];
            if ($urandom_range(0, 99) < 22) gnt[c] = ~gnt[c];
         end
         rst_n = ($urandom_range(0, 799) != 0);
         @(negedge clk);
      end
      rst_n = 1'b1; req = '0; gnt = '0;
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
